// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-to-execute pipeline register for the RV32I integer ALU.
// Decodes OP, OP-IMM, LUI and AUIPC into the ALU opcode and operands, registers
// them with a valid bit, honours stall/flush from the hazard unit and counts
// legal issued instructions.
//
// Optional feature macro: ALU_ISSUE_BUBBLE_CLR_EN
//   defined     -> bubbles and flushes zero aluA, aluB, aluOp and rdAddr
//   not defined -> bubbles and flushes leave the data fields untouched
module alu_issue_stage (
    input  logic        clk,
    input  logic        rstN,
    input  logic        inValid,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1Data,
    input  logic [31:0] rs2Data,
    input  logic        stall,
    input  logic        flush,
    output logic        exValid,
    output logic [31:0] aluA,
    output logic [31:0] aluB,
    output logic [3:0]  aluOp,
    output logic [4:0]  rdAddr,
    output logic        regWrite,
    output logic        illegal,
    output logic [31:0] issuedCnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // Instruction fields
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] immI;
    logic [31:0] immU;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign shamt  = instr[24:20];
    assign funct7 = instr[31:25];
    assign immI   = {{20{instr[31]}}, instr[31:20]};
    assign immU   = {instr[31:12], 12'b0};

    // Decoded (combinational) results for the instruction on the inputs
    logic [31:0] decA;
    logic [31:0] decB;
    logic [3:0]  decOp;
    logic        decLegal;

    // Stage registers and their next-state values
    logic        exValid_q,   exValid_d;
    logic [31:0] aluA_q,      aluA_d;
    logic [31:0] aluB_q,      aluB_d;
    logic [3:0]  aluOp_q,     aluOp_d;
    logic [4:0]  rdAddr_q,    rdAddr_d;
    logic        regWrite_q,  regWrite_d;
    logic        illegal_q,   illegal_d;
    logic [31:0] issuedCnt_q, issuedCnt_d;

    // Stage control: a capture takes a real instruction, a clear slot is a
    // flush or a bubble (no instruction offered while not stalled).
    logic doCapture;
    logic doClear;

    assign doCapture = !flush && !stall && inValid;
    assign doClear   = flush || (!stall && !inValid);

    // Decode the presented instruction into ALU operands, opcode and legality
    always_comb begin
        decA     = 32'b0;
        decB     = 32'b0;
        decOp    = 4'b0000;
        decLegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                decA = rs1Data;
                decB = rs2Data;
                if (funct7 == F7_BASE) begin
                    decLegal = 1'b1;
                    decOp    = {1'b0, funct3};
                end else if ((funct7 == F7_ALT) &&
                             ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA))) begin
                    decLegal = 1'b1;
                    decOp    = {1'b1, funct3};
                end
            end
            OPC_OP_IMM: begin
                decA = rs1Data;
                case (funct3)
                    F3_SLL: begin
                        decB     = {27'b0, shamt};
                        decOp    = {1'b0, F3_SLL};
                        decLegal = (funct7 == F7_BASE);
                    end
                    F3_SRL_SRA: begin
                        decB     = {27'b0, shamt};
                        decOp    = {instr[30], F3_SRL_SRA};
                        decLegal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    default: begin
                        decB     = immI;
                        decOp    = {1'b0, funct3};
                        decLegal = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                decA     = 32'b0;
                decB     = immU;
                decOp    = 4'b0000;
                decLegal = 1'b1;
            end
            OPC_AUIPC: begin
                decA     = pc;
                decB     = immU;
                decOp    = 4'b0000;
                decLegal = 1'b1;
            end
            default: begin
                decLegal = 1'b0;
            end
        endcase
        // Unsupported encodings present a harmless add to the ALU
        if (!decLegal) begin
            decOp = 4'b0000;
        end
    end

    // Next-state selection: flush beats stall, stall beats capture
    always_comb begin
        exValid_d   = exValid_q;
        aluA_d      = aluA_q;
        aluB_d      = aluB_q;
        aluOp_d     = aluOp_q;
        rdAddr_d    = rdAddr_q;
        regWrite_d  = regWrite_q;
        illegal_d   = illegal_q;
        issuedCnt_d = issuedCnt_q;
        if (doClear) begin
            exValid_d  = 1'b0;
            regWrite_d = 1'b0;
            illegal_d  = 1'b0;
`ifdef ALU_ISSUE_BUBBLE_CLR_EN
            aluA_d     = 32'b0;
            aluB_d     = 32'b0;
            aluOp_d    = 4'b0000;
            rdAddr_d   = 5'b0;
`endif
        end else if (doCapture) begin
            exValid_d  = 1'b1;
            aluA_d     = decA;
            aluB_d     = decB;
            aluOp_d    = decOp;
            rdAddr_d   = rd;
            regWrite_d = decLegal && (rd != 5'b0);
            illegal_d  = !decLegal;
            if (decLegal) begin
                issuedCnt_d = issuedCnt_q + 32'd1;
            end
        end
    end

    // Stage register with synchronous active-low reset over every output
    always_ff @(posedge clk) begin
        if (!rstN) begin
            exValid_q   <= 1'b0;
            aluA_q      <= 32'b0;
            aluB_q      <= 32'b0;
            aluOp_q     <= 4'b0000;
            rdAddr_q    <= 5'b0;
            regWrite_q  <= 1'b0;
            illegal_q   <= 1'b0;
            issuedCnt_q <= 32'b0;
        end else begin
            exValid_q   <= exValid_d;
            aluA_q      <= aluA_d;
            aluB_q      <= aluB_d;
            aluOp_q     <= aluOp_d;
            rdAddr_q    <= rdAddr_d;
            regWrite_q  <= regWrite_d;
            illegal_q   <= illegal_d;
            issuedCnt_q <= issuedCnt_d;
        end
    end

    assign exValid   = exValid_q;
    assign aluA      = aluA_q;
    assign aluB      = aluB_q;
    assign aluOp     = aluOp_q;
    assign rdAddr    = rdAddr_q;
    assign regWrite  = regWrite_q;
    assign illegal   = illegal_q;
    assign issuedCnt = issuedCnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage. Expected values are hand-computed
// from the RV32I encodings; data-retention expectations follow
// ALU_ISSUE_BUBBLE_CLR_EN when it is defined for the build.
module tb_alu_issue_stage;

    logic        clk;
    logic        rstN;
    logic        inValid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic        stall;
    logic        flush;
    logic        exValid;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [3:0]  aluOp;
    logic [4:0]  rdAddr;
    logic        regWrite;
    logic        illegal;
    logic [31:0] issuedCnt;

    int checks;
    int failures;

`ifdef ALU_ISSUE_BUBBLE_CLR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    alu_issue_stage dut (
        .clk       (clk),
        .rstN      (rstN),
        .inValid   (inValid),
        .instr     (instr),
        .pc        (pc),
        .rs1Data   (rs1Data),
        .rs2Data   (rs2Data),
        .stall     (stall),
        .flush     (flush),
        .exValid   (exValid),
        .aluA      (aluA),
        .aluB      (aluB),
        .aluOp     (aluOp),
        .rdAddr    (rdAddr),
        .regWrite  (regWrite),
        .illegal   (illegal),
        .issuedCnt (issuedCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op, input logic [4:0] rd,
                           input logic rw, input logic ill, input logic [31:0] cnt);
        chk({tag, ".exValid"},   {31'b0, exValid},  {31'b0, ev});
        chk({tag, ".aluA"},      aluA,              a);
        chk({tag, ".aluB"},      aluB,              b);
        chk({tag, ".aluOp"},     {28'b0, aluOp},    {28'b0, op});
        chk({tag, ".rdAddr"},    {27'b0, rdAddr},   {27'b0, rd});
        chk({tag, ".regWrite"},  {31'b0, regWrite}, {31'b0, rw});
        chk({tag, ".illegal"},   {31'b0, illegal},  {31'b0, ill});
        chk({tag, ".issuedCnt"}, issuedCnt,         cnt);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic st, input logic fl);
        inValid = v;
        instr   = ins;
        pc      = p;
        rs1Data = r1;
        rs2Data = r2;
        stall   = st;
        flush   = fl;
    endtask

    // Advance one active edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstN     = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        tick();
        chk_all("reset", 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 32'd0);

        rstN = 1'b1;
        // add x3,x1,x2
        drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        chk_all("add", 1'b1, 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0, 32'd1);

        // sub x3,x1,x2
        drive(1'b1, 32'h402081B3, 32'h0, 32'd10, 32'd3, 1'b0, 1'b0);
        tick();
        chk_all("sub", 1'b1, 32'd10, 32'd3, 4'b1000, 5'd3, 1'b1, 1'b0, 32'd2);

        // srai x5,x6,3
        drive(1'b1, 32'h40335293, 32'h0, 32'h80000000, 32'h12345678, 1'b0, 1'b0);
        tick();
        chk_all("srai", 1'b1, 32'h80000000, 32'd3, 4'b1101, 5'd5, 1'b1, 1'b0, 32'd3);

        // addi x1,x0,-1
        drive(1'b1, 32'hFFF00093, 32'h0, 32'h0, 32'hAAAA5555, 1'b0, 1'b0);
        tick();
        chk_all("addi", 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 1'b0, 32'd4);

        // lui x2,0x12345 (rs1Data must not leak into A)
        drive(1'b1, 32'h12345137, 32'h40, 32'h0000DEAD, 32'h0000BEEF, 1'b0, 1'b0);
        tick();
        chk_all("lui", 1'b1, 32'h0, 32'h12345000, 4'b0000, 5'd2, 1'b1, 1'b0, 32'd5);

        // auipc x4,0x1 at pc=0x100
        drive(1'b1, 32'h00001217, 32'h100, 32'h0000DEAD, 32'h0, 1'b0, 1'b0);
        tick();
        chk_all("auipc", 1'b1, 32'h100, 32'h1000, 4'b0000, 5'd4, 1'b1, 1'b0, 32'd6);

        // add x0,x1,x2: legal, counted, but no write-back
        drive(1'b1, 32'h00208033, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0);
        tick();
        chk_all("rd0", 1'b1, 32'd1, 32'd2, 4'b0000, 5'd0, 1'b0, 1'b0, 32'd7);

        // mul x3,x1,x2: illegal funct7
        drive(1'b1, 32'h022081B3, 32'h0, 32'd4, 32'd6, 1'b0, 1'b0);
        tick();
        chk("mul.exValid",   {31'b0, exValid},  32'd1);
        chk("mul.illegal",   {31'b0, illegal},  32'd1);
        chk("mul.regWrite",  {31'b0, regWrite}, 32'd0);
        chk("mul.aluOp",     {28'b0, aluOp},    32'd0);
        chk("mul.issuedCnt", issuedCnt,         32'd7);

        // slli x1,x1,1 with imm[11:5]=0100000 is illegal
        drive(1'b1, 32'h40109093, 32'h0, 32'd4, 32'd6, 1'b0, 1'b0);
        tick();
        chk("slli_bad.illegal",   {31'b0, illegal}, 32'd1);
        chk("slli_bad.issuedCnt", issuedCnt,        32'd7);

        // sltu x3,x1,x2
        drive(1'b1, 32'h0020B1B3, 32'h0, 32'd9, 32'd8, 1'b0, 1'b0);
        tick();
        chk_all("sltu", 1'b1, 32'd9, 32'd8, 4'b0011, 5'd3, 1'b1, 1'b0, 32'd8);

        // Known state before the stall
        drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        chk_all("pre_stall", 1'b1, 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0, 32'd9);

        // Three stalled cycles with changing inputs: everything holds
        drive(1'b1, 32'h402081B3, 32'h0, 32'd100, 32'd200, 1'b1, 1'b0);
        tick();
        chk_all("stall1", 1'b1, 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0, 32'd9);
        drive(1'b0, 32'h40335293, 32'h0, 32'd101, 32'd201, 1'b1, 1'b0);
        tick();
        chk_all("stall2", 1'b1, 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0, 32'd9);
        drive(1'b1, 32'h022081B3, 32'h0, 32'd102, 32'd202, 1'b1, 1'b0);
        tick();
        chk_all("stall3", 1'b1, 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0, 32'd9);

        // Release: the presented sub is captured exactly once
        drive(1'b1, 32'h402081B3, 32'h0, 32'd20, 32'd1, 1'b0, 1'b0);
        tick();
        chk_all("release", 1'b1, 32'd20, 32'd1, 4'b1000, 5'd3, 1'b1, 1'b0, 32'd10);

        // stall+flush together: flush wins
        drive(1'b1, 32'h002081B3, 32'h0, 32'd99, 32'd98, 1'b1, 1'b1);
        tick();
        chk_all("flush", 1'b0, CLR ? 32'd0 : 32'd20, CLR ? 32'd0 : 32'd1,
                CLR ? 4'b0000 : 4'b1000, CLR ? 5'd0 : 5'd3, 1'b0, 1'b0, 32'd10);

        // Capture then bubble
        drive(1'b1, 32'h0020C233, 32'h0, 32'h0000F0F0, 32'h00000FF0, 1'b0, 1'b0);
        tick();
        chk_all("xor", 1'b1, 32'h0000F0F0, 32'h00000FF0, 4'b0100, 5'd4, 1'b1, 1'b0, 32'd11);
        drive(1'b0, 32'h002081B3, 32'h0, 32'd77, 32'd66, 1'b0, 1'b0);
        tick();
        chk_all("bubble", 1'b0, CLR ? 32'd0 : 32'h0000F0F0, CLR ? 32'd0 : 32'h00000FF0,
                CLR ? 4'b0000 : 4'b0100, CLR ? 5'd0 : 5'd4, 1'b0, 1'b0, 32'd11);

        // Reset mid-stream overrides stall
        drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        tick();
        chk("pre_reset.issuedCnt", issuedCnt, 32'd12);
        rstN = 1'b0;
        drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        tick();
        chk_all("mid_reset", 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 32'd0);
        rstN = 1'b1;

        // Counter wrap: preload the count register to all ones, then issue once
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        force dut.issuedCnt_q = 32'hFFFFFFFF;
        #1;
        release dut.issuedCnt_q;
        chk("preload.issuedCnt", issuedCnt, 32'hFFFFFFFF);
        drive(1'b1, 32'h00108093, 32'h0, 32'd1, 32'd0, 1'b0, 1'b0);
        tick();
        chk_all("wrap", 1'b1, 32'd1, 32'd1, 4'b0000, 5'd1, 1'b1, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
